// File: rtl/blackparrot_fpga_host_mmio_arb_if.sv
// Bundle of requester-side and host-MMIO-side signals around the arbiter.
// The master modport is the arbiter's view. The slave modport is the view of
// the requesters and host buffers around it.
interface blackparrot_fpga_host_mmio_arb_if #(
  parameter int num_req_p = 2
);
  // requester request side
  logic [num_req_p-1:0]    req_v_i;
  logic [num_req_p-1:0]    req_w_i;
  logic [num_req_p*32-1:0] req_addr_i;
  logic [num_req_p*32-1:0] req_data_i;
  logic [num_req_p-1:0]    req_yumi_o;
  // requester response side
  logic [num_req_p-1:0]    resp_v_o;
  logic [num_req_p-1:0]    resp_w_o;
  logic [num_req_p*32-1:0] resp_data_o;
  logic [num_req_p-1:0]    resp_ready_and_i;
  // host MMIO request FIFO
  logic                    mmio_req_v_o;
  logic [31:0]             mmio_req_data_o;
  logic                    mmio_req_ready_and_i;
  // host MMIO response FIFO head
  logic                    mmio_resp_v_i;
  logic [31:0]             mmio_resp_data_i;
  logic                    mmio_resp_yumi_o;

  modport master (
    input  req_v_i, req_w_i, req_addr_i, req_data_i, resp_ready_and_i,
           mmio_req_ready_and_i, mmio_resp_v_i, mmio_resp_data_i,
    output req_yumi_o, resp_v_o, resp_w_o, resp_data_o,
           mmio_req_v_o, mmio_req_data_o, mmio_resp_yumi_o
  );

  modport slave (
    output req_v_i, req_w_i, req_addr_i, req_data_i, resp_ready_and_i,
           mmio_req_ready_and_i, mmio_resp_v_i, mmio_resp_data_i,
    input  req_yumi_o, resp_v_o, resp_w_o, resp_data_o,
           mmio_req_v_o, mmio_req_data_o, mmio_resp_yumi_o
  );
endinterface

// File: rtl/blackparrot_fpga_host_mmio_arb.sv
// Round-robin arbiter sharing the 32b host MMIO request/response channel
// between num_req_p requesters. Each grant is sent as an address beat then a
// data beat. Read responses return in grant order through a small order FIFO.
// Writes are acknowledged locally.
// Optional macro BP_FPGA_HOST_MMIO_ARB_TIMEOUT_EN adds a read-response timeout
// that answers 32'hDEADBEEF and discards the late host response.
module blackparrot_fpga_host_mmio_arb #(
  parameter int num_req_p        = 2,
  parameter int timeout_cycles_p = 2**20
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  blackparrot_fpga_host_mmio_arb_if.master bus,
  output logic [$clog2(num_req_p+1)-1:0] outstanding_o,
  output logic                           timeout_o
);
  localparam int id_w  = $clog2(num_req_p);
  localparam int cnt_w = $clog2(num_req_p+1);

  typedef enum logic [1:0] {e_arb, e_addr, e_data} state_e;

  state_e               state_q, state_d;
  logic [id_w-1:0]      grant_q, grant_d;
  logic [id_w-1:0]      rr_ptr_q, rr_ptr_d;
  logic [num_req_p-1:0] busy_q, busy_d;
  logic [num_req_p-1:0] wack_q, wack_d;

  // Order FIFO: one entry per outstanding read, holding the requester id.
  logic [id_w-1:0]      ord_mem [num_req_p];
  logic [id_w-1:0]      ord_wr_q, ord_wr_d;
  logic [id_w-1:0]      ord_rd_q, ord_rd_d;
  logic [cnt_w-1:0]     ord_cnt_q, ord_cnt_d;
  logic [id_w-1:0]      head;

  logic [num_req_p-1:0] eligible;
  logic [num_req_p-1:0] resp_hs;
  logic                 arb_found;
  logic [id_w-1:0]      arb_idx;
  logic [id_w-1:0]      cand;
  logic                 data_hs;
  logic                 push;
  logic                 pop;

`ifdef BP_FPGA_HOST_MMIO_ARB_TIMEOUT_EN
  localparam int          tmr_w           = $clog2(timeout_cycles_p+1);
  localparam logic [31:0] timeout_data_lp = 32'hDEADBEEF;
  logic [tmr_w-1:0] timer_q, timer_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             timeout_q, timeout_d;
  logic             to_fire;
  logic             timer_hit;
`endif

  // Circular increment for ids and FIFO pointers, also for non power-of-two counts.
  function automatic logic [id_w-1:0] ptr_inc(input logic [id_w-1:0] p);
    if (p == id_w'(num_req_p - 1)) return '0;
    else                           return p + 1'b1;
  endfunction

  assign eligible      = bus.req_v_i & ~busy_q;
  assign head          = ord_mem[ord_rd_q];
  assign resp_hs       = bus.resp_v_o & bus.resp_ready_and_i;
  assign outstanding_o = ord_cnt_q;

  // Round-robin search starting one past the last grant, with wrap-around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = rr_ptr_q;
    for (int i = 0; i < num_req_p; i++) begin
      cand = ptr_inc(cand);
      if (!arb_found && eligible[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= e_arb;
    else                state_q <= state_d;
  end

  // FSM next state: arbitrate, then one address beat, then one data beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_arb:   if (arb_found)                state_d = e_addr;
      e_addr:  if (bus.mmio_req_ready_and_i) state_d = e_data;
      e_data:  if (bus.mmio_req_ready_and_i) state_d = e_arb;
      default:                               state_d = e_arb;
    endcase
  end

  // FSM outputs: drive the beat for the held grant and consume the request on the data beat.
  always_comb begin
    bus.mmio_req_v_o    = 1'b0;
    bus.mmio_req_data_o = '0;
    bus.req_yumi_o      = '0;
    data_hs             = 1'b0;
    case (state_q)
      e_addr: begin
        bus.mmio_req_v_o    = 1'b1;
        bus.mmio_req_data_o = bus.req_addr_i[32*int'(grant_q) +: 32];
      end
      e_data: begin
        bus.mmio_req_v_o    = 1'b1;
        bus.mmio_req_data_o = bus.req_data_i[32*int'(grant_q) +: 32];
        if (bus.mmio_req_ready_and_i) begin
          bus.req_yumi_o[grant_q] = 1'b1;
          data_hs                 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign push = data_hs & ~bus.req_w_i[grant_q];

  // Response routing: local write acks plus the host response steered to the order-FIFO head.
  always_comb begin
    bus.resp_v_o         = wack_q;
    bus.resp_w_o         = wack_q;
    bus.resp_data_o      = '0;
    bus.mmio_resp_yumi_o = 1'b0;
    pop                  = 1'b0;
`ifdef BP_FPGA_HOST_MMIO_ARB_TIMEOUT_EN
    to_fire = 1'b0;
    // Late responses belonging to timed-out reads are swallowed here.
    if (drop_cnt_q != '0) bus.mmio_resp_yumi_o = bus.mmio_resp_v_i;
    if (ord_cnt_q != '0) begin
      if (timer_hit) begin
        bus.resp_v_o[head]               = 1'b1;
        bus.resp_w_o[head]               = 1'b0;
        bus.resp_data_o[32*int'(head) +: 32] = timeout_data_lp;
        to_fire                          = bus.resp_ready_and_i[head];
        pop                              = to_fire;
      end else if (drop_cnt_q == '0) begin
        bus.resp_v_o[head]               = bus.mmio_resp_v_i;
        bus.resp_w_o[head]               = 1'b0;
        bus.resp_data_o[32*int'(head) +: 32] = bus.mmio_resp_data_i;
        bus.mmio_resp_yumi_o             = bus.mmio_resp_v_i & bus.resp_ready_and_i[head];
        pop                              = bus.mmio_resp_yumi_o;
      end
    end
`else
    if (ord_cnt_q != '0) begin
      bus.resp_v_o[head]               = bus.mmio_resp_v_i;
      bus.resp_w_o[head]               = 1'b0;
      bus.resp_data_o[32*int'(head) +: 32] = bus.mmio_resp_data_i;
      bus.mmio_resp_yumi_o             = bus.mmio_resp_v_i & bus.resp_ready_and_i[head];
      pop                              = bus.mmio_resp_yumi_o;
    end
`endif
  end

  // Control next state: grant pointer, busy/wack bits and order-FIFO bookkeeping.
  always_comb begin
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == e_arb && arb_found) begin
      grant_d  = arb_idx;
      rr_ptr_d = arb_idx;
    end
    busy_d = busy_q & ~resp_hs;
    wack_d = wack_q & ~resp_hs;
    if (data_hs) begin
      busy_d[grant_q] = 1'b1;
      if (bus.req_w_i[grant_q]) wack_d[grant_q] = 1'b1;
    end
    ord_wr_d  = push ? ptr_inc(ord_wr_q) : ord_wr_q;
    ord_rd_d  = pop  ? ptr_inc(ord_rd_q) : ord_rd_q;
    ord_cnt_d = ord_cnt_q + cnt_w'(push) - cnt_w'(pop);
  end

  // Control registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      grant_q   <= '0;
      rr_ptr_q  <= id_w'(num_req_p - 1);
      busy_q    <= '0;
      wack_q    <= '0;
      ord_wr_q  <= '0;
      ord_rd_q  <= '0;
      ord_cnt_q <= '0;
    end else begin
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      wack_q    <= wack_d;
      ord_wr_q  <= ord_wr_d;
      ord_rd_q  <= ord_rd_d;
      ord_cnt_q <= ord_cnt_d;
    end
  end

  // Order-FIFO storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge s_axi_aclk) begin
    if (push) ord_mem[ord_wr_q] <= grant_q;
  end

`ifdef BP_FPGA_HOST_MMIO_ARB_TIMEOUT_EN
  assign timer_hit = (timer_q == tmr_w'(timeout_cycles_p));
  assign timeout_o = timeout_q;

  // Timeout next state: count while a read waits with no host response, restart on every pop.
  always_comb begin
    timer_d = timer_q;
    if (pop)
      timer_d = '0;
    else if (ord_cnt_q != '0 && !bus.mmio_resp_v_i && !timer_hit)
      timer_d = timer_q + 1'b1;
    drop_cnt_d = drop_cnt_q + 16'(to_fire)
               - 16'(drop_cnt_q != '0 && bus.mmio_resp_v_i);
    timeout_d  = timeout_q | to_fire;
  end

  // Timeout registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      timer_q    <= '0;
      drop_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      drop_cnt_q <= drop_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  // Without the timeout feature reads wait forever and the flag never rises.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (timeout_cycles_p > 0);
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_blackparrot_fpga_host_mmio_arb.sv
// Directed bench for blackparrot_fpga_host_mmio_arb with two requesters.
module tb_blackparrot_fpga_host_mmio_arb;
  localparam int N = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] outstanding;
  logic       timeout;
  int         errors;
  int         checks;

  blackparrot_fpga_host_mmio_arb_if #(.num_req_p(N)) bus ();

  blackparrot_fpga_host_mmio_arb #(
    .num_req_p       (N),
    .timeout_cycles_p(16)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .bus          (bus),
    .outstanding_o(outstanding),
    .timeout_o    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Present a request from requester k and hold it until it is consumed.
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    bus.req_w_i[k]             = w;
    bus.req_addr_i[k*32 +: 32] = a;
    bus.req_data_i[k*32 +: 32] = d;
    bus.req_v_i[k]             = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (bus.req_yumi_o[k]) done = 1'b1;
      next();
    end
    bus.req_v_i[k] = 1'b0;
    if (!done) check("yumi_wait", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] order [4];
    bit          found;

    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    bus.req_v_i              = '0;
    bus.req_w_i              = '0;
    bus.req_addr_i           = '0;
    bus.req_data_i           = '0;
    bus.resp_ready_and_i     = '1;
    bus.mmio_req_ready_and_i = 1'b1;
    bus.mmio_resp_v_i        = 1'b0;
    bus.mmio_resp_data_i     = '0;

    // reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mmio_v",    32'(bus.mmio_req_v_o), 32'd0);
    check("rst_yumi",      32'(bus.req_yumi_o), 32'd0);
    check("rst_resp_v",    32'(bus.resp_v_o), 32'd0);
    check("rst_resp_yumi", 32'(bus.mmio_resp_yumi_o), 32'd0);
    check("rst_outst",     32'(outstanding), 32'd0);
    check("rst_timeout",   32'(timeout), 32'd0);
    rst_n = 1'b1;
    next();

    // round robin: both hold writes, grants alternate starting with 0
    bus.req_w_i        = 2'b11;
    bus.req_addr_i     = {32'h0000_1001, 32'h0000_1000};
    bus.req_data_i     = {32'h0000_0011, 32'h0000_0010};
    bus.req_v_i        = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (bus.req_yumi_o != '0) begin
        order[n] = bus.req_yumi_o[1] ? 32'd1 : 32'd0;
        n++;
      end
      next();
    end
    bus.req_v_i = '0;
    check("rr_count", 32'(n), 32'd4);
    check("rr_g0", order[0], 32'd0);
    check("rr_g1", order[1], 32'd1);
    check("rr_g2", order[2], 32'd0);
    check("rr_g3", order[3], 32'd1);
    repeat (3) next();

    // single write with cycle-exact beats and ack
    bus.req_w_i[0]         = 1'b1;
    bus.req_addr_i[31:0]   = 32'h0010_2000;
    bus.req_data_i[31:0]   = 32'h0000_0055;
    bus.req_v_i[0]         = 1'b1;
    #1;
    check("wr_c0_v", 32'(bus.mmio_req_v_o), 32'd0);
    next(); #1;
    check("wr_c1_v",    32'(bus.mmio_req_v_o), 32'd1);
    check("wr_c1_addr", bus.mmio_req_data_o, 32'h0010_2000);
    check("wr_c1_yumi", 32'(bus.req_yumi_o), 32'd0);
    next(); #1;
    check("wr_c2_data", bus.mmio_req_data_o, 32'h0000_0055);
    check("wr_c2_yumi", 32'(bus.req_yumi_o), 32'b01);
    next();
    bus.req_v_i[0] = 1'b0;
    #1;
    check("wr_c3_resp_v", 32'(bus.resp_v_o), 32'b01);
    check("wr_c3_resp_w", 32'(bus.resp_w_o[0]), 32'd1);
    check("wr_c3_data",   bus.resp_data_o[31:0], 32'd0);
    next(); #1;
    check("wr_c4_resp_v", 32'(bus.resp_v_o), 32'd0);

    // reads from 1 then 0, host answers in order 0xA then 0xB
    issue(1, 1'b0, 32'h0000_2001, 32'h0000_0004);
    #1;
    check("rd_outst1", 32'(outstanding), 32'd1);
    issue(0, 1'b0, 32'h0000_2000, 32'h0000_0004);
    #1;
    check("rd_outst2", 32'(outstanding), 32'd2);
    bus.mmio_resp_v_i    = 1'b1;
    bus.mmio_resp_data_i = 32'h0000_000A;
    #1;
    check("rd_a_resp_v", 32'(bus.resp_v_o), 32'b10);
    check("rd_a_data",   bus.resp_data_o[63:32], 32'h0000_000A);
    check("rd_a_w",      32'(bus.resp_w_o), 32'd0);
    check("rd_a_yumi",   32'(bus.mmio_resp_yumi_o), 32'd1);
    next();
    bus.mmio_resp_data_i = 32'h0000_000B;
    #1;
    check("rd_outst3",   32'(outstanding), 32'd1);
    check("rd_b_resp_v", 32'(bus.resp_v_o), 32'b01);
    check("rd_b_data",   bus.resp_data_o[31:0], 32'h0000_000B);
    check("rd_b_other",  bus.resp_data_o[63:32], 32'd0);
    next();
    bus.mmio_resp_v_i = 1'b0;
    #1;
    check("rd_outst4", 32'(outstanding), 32'd0);
    check("rd_idle_v", 32'(bus.resp_v_o), 32'd0);

    // backpressure on the address beat while requester 1 also waits
    bus.mmio_req_ready_and_i = 1'b0;
    bus.req_w_i              = 2'b11;
    bus.req_addr_i           = {32'h0000_4000, 32'h0000_3000};
    bus.req_data_i           = {32'h0000_0044, 32'h0000_0033};
    bus.req_v_i[0]           = 1'b1;
    next();
    bus.req_v_i[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_v",    32'(bus.mmio_req_v_o), 32'd1);
      check("bp_addr", bus.mmio_req_data_o, 32'h0000_3000);
      check("bp_yumi", 32'(bus.req_yumi_o), 32'd0);
      next();
    end
    bus.mmio_req_ready_and_i = 1'b1;
    #1;
    check("bp_rel_addr", bus.mmio_req_data_o, 32'h0000_3000);
    next(); #1;
    check("bp_data", bus.mmio_req_data_o, 32'h0000_0033);
    check("bp_yumi", 32'(bus.req_yumi_o), 32'b01);
    next();
    bus.req_v_i[0] = 1'b0;
    issue(1, 1'b1, 32'h0000_4000, 32'h0000_0044);
    repeat (3) next();

    // reset in the data beat; afterwards requester 0 wins again
    issue(0, 1'b1, 32'h0000_5000, 32'h0000_0050);
    repeat (3) next();
    bus.req_addr_i[31:0] = 32'h0000_5100;
    bus.req_data_i[31:0] = 32'h0000_0051;
    bus.req_v_i[0]       = 1'b1;
    next();
    next();
    bus.mmio_req_ready_and_i = 1'b0;
    #1;
    check("mr_data_beat", bus.mmio_req_data_o, 32'h0000_0051);
    rst_n = 1'b0;
    #1;
    check("mr_mmio_v",  32'(bus.mmio_req_v_o), 32'd0);
    check("mr_mmio_d",  bus.mmio_req_data_o, 32'd0);
    check("mr_yumi",    32'(bus.req_yumi_o), 32'd0);
    check("mr_resp_v",  32'(bus.resp_v_o), 32'd0);
    next();
    rst_n                    = 1'b1;
    bus.mmio_req_ready_and_i = 1'b1;
    bus.req_v_i              = 2'b11;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (bus.req_yumi_o != '0) begin
        found = 1'b1;
        check("mr_first_grant", 32'(bus.req_yumi_o), 32'b01);
      end
      next();
    end
    if (!found) check("mr_grant_wait", 32'd0, 32'd1);
    bus.req_v_i[0] = 1'b0;
    issue(1, 1'b1, 32'h0000_4000, 32'h0000_0044);
    repeat (3) next();

`ifdef BP_FPGA_HOST_MMIO_ARB_TIMEOUT_EN
    // unanswered read times out after 16 cycles; late response is dropped
    issue(0, 1'b0, 32'h0000_6000, 32'h0000_0004);
    for (int c = 0; c <= 16; c++) begin
      #1;
      if (c < 16) begin
        check("to_quiet", 32'(bus.resp_v_o), 32'd0);
      end else begin
        check("to_resp_v", 32'(bus.resp_v_o), 32'b01);
        check("to_data",   bus.resp_data_o[31:0], 32'hDEADBEEF);
        check("to_w",      32'(bus.resp_w_o), 32'd0);
      end
      next();
    end
    #1;
    check("to_flag",  32'(timeout), 32'd1);
    check("to_outst", 32'(outstanding), 32'd0);
    bus.mmio_resp_v_i    = 1'b1;
    bus.mmio_resp_data_i = 32'h0000_0077;
    #1;
    check("to_drop_yumi", 32'(bus.mmio_resp_yumi_o), 32'd1);
    check("to_drop_v",    32'(bus.resp_v_o), 32'd0);
    next();
    #1;
    check("to_drop_done", 32'(bus.mmio_resp_yumi_o), 32'd0);
    bus.mmio_resp_v_i = 1'b0;
    next();
`else
    #1;
    check("timeout_tied", 32'(timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/blackparrot_fpga_host_mmio_arb.md
# blackparrot_fpga_host_mmio_arb

Round-robin arbiter that shares the single 32b host MMIO request/response channel between `num_req_p` BlackParrot I/O requesters. Each granted request is serialized as an address beat then a data beat into the host MMIO request FIFO. Host read responses are routed back in grant order via an internal order FIFO, and writes are acknowledged locally. It sits between the per-requester AXI-to-FIFO converters and the host MMIO request/response buffers.

## Interface
- `num_req_p`, 2: number of requesters (2..8).
- `timeout_cycles_p`, 2**20: read-response timeout in cycles; used only under the timeout macro.
- `s_axi_aclk  in  1`: clock. One clock domain.
- `s_axi_aresetn  in  1`: reset, asynchronous and active-low.
- `req_v_i  in  num_req_p`: requester k has a request pending.
- `req_w_i  in  num_req_p`: 1 = write, 0 = read.
- `req_addr_i  in  num_req_p*32`: request address, slice k.
- `req_data_i  in  num_req_p*32`: write data (or read size/offset word), slice k.
- `req_yumi_o  out  num_req_p`: request consumed.
- `resp_v_o  out  num_req_p`: response valid to requester k.
- `resp_w_o  out  num_req_p`: response is a write ack.
- `resp_data_o  out  num_req_p*32`: response data, slice k.
- `resp_ready_and_i  in  num_req_p`: requester k accepts its response.
- `mmio_req_v_o  out  1`, `mmio_req_data_o  out  32`, `mmio_req_ready_and_i  in  1`: valid/ready port into the host request FIFO.
- `mmio_resp_v_i  in  1`, `mmio_resp_data_i  in  32`, `mmio_resp_yumi_o  out  1`: host response FIFO head.
- `outstanding_o  out  clog2(num_req_p+1)`: number of reads awaiting a host response.
- `timeout_o  out  1`: sticky flag, set when any read has timed out.

## Operation
- **Per-requester busy bit.** Set when k's data beat is accepted. Cleared when k's response handshakes (`resp_v_o[k] & resp_ready_and_i[k]`). A requester is eligible only when `req_v_i[k] & ~busy[k]`. This allows at most one outstanding transaction per requester, so the order FIFO (depth `num_req_p`) never overflows.
- **FSM states:**
  - `e_arb`: if any requester is eligible, register the grant (`grant_r`), update `rr_ptr_r` to the granted index, and go to `e_addr`. Priority search starts at `rr_ptr_r+1` modulo `num_req_p`, with wrap-around.
  - `e_addr`: `mmio_req_v_o=1`, data = `req_addr_i[grant_r]`. On ready, go to `e_data`.
  - `e_data`: `mmio_req_v_o=1`, data = `req_data_i[grant_r]`. On ready, `req_yumi_o[grant_r]=1` and go to `e_arb`.
    - Read: push `grant_r` to the order FIFO.
    - Write: set `wack_r[grant_r]`.
- **Write ack:** `resp_v_o[k]=wack_r[k]`, `resp_w_o[k]=1`, data 0. `wack_r[k]` clears on handshake.
- **Read response:** with head id h of the order FIFO:
  - `resp_v_o[h]=mmio_resp_v_i`, `resp_data_o[h]=mmio_resp_data_i`, `resp_w_o[h]=0`.
  - `mmio_resp_yumi_o = mmio_resp_v_i & resp_ready_and_i[h]`.
  - On yumi, pop the order FIFO.
- **No response conflict.** A single requester can never have a write ack and a read response at the same time, because busy prevents it. Unused `resp_data_o` slices drive 0.
- **`req_v_i` drop.** Requesters must hold `req_v_i` and their fields stable until yumi. A drop during `e_addr`/`e_data` is a protocol error; the FSM continues with the held grant.
- **Simultaneous events.** A push and a pop of the order FIFO in the same cycle are both legal; `outstanding_o` is unchanged. A response that clears busy[k] makes k eligible in `e_arb` in the next cycle, not the same cycle.
- **Reset values:** state `e_arb`, `rr_ptr_r = num_req_p-1` (requester 0 wins first), busy=0, wack=0, order FIFO empty. All outputs 0, `outstanding_o=0`, `timeout_o=0`.
- **Reset mid-transaction.** An asynchronous reset mid-transaction discards it with no further beats.

## Timing
- A request seen in `e_arb` at cycle 0 produces the address beat at cycle 1 and the data beat at cycle 2 at the earliest.
- `req_yumi_o` is asserted in the data-handshake cycle.
- A write ack is valid in the cycle after the data handshake.
- The read-response path is combinational from `mmio_resp_v_i` to `resp_v_o`.
- Best-case throughput is 3 cycles per request.

## Configuration
- **`BP_FPGA_HOST_MMIO_ARB_TIMEOUT_EN` defined:**
  - A counter runs while the order FIFO is non-empty and no host response is valid; it resets on every pop.
  - When the count reaches `timeout_cycles_p`, the head requester receives data `32'hDEADBEEF` (w=0) held until handshake, then the head is popped, `timeout_o` is set, and a drop counter is incremented.
  - While the drop counter is non-zero, `mmio_resp_yumi_o=mmio_resp_v_i` and the host response is discarded; each discard decrements the counter.
- **Undefined:** reads wait indefinitely, and `timeout_o` is tied to 0.

## Test plan
- **Single write:** req0 w=1, addr 0x0010_2000, data 0x55 → beats 0x0010_2000 then 0x55 on cycles 1 and 2; `req_yumi_o[0]` at cycle 2; write ack (w=1, data 0) at cycle 3.
- **Round robin:** req0 and req1 both hold writes continuously → grant order 0, 1, 0, 1. After reset, requester 0 wins first.
- **Out-of-order host readiness:** req1 read then req0 read, host returns 0xA then 0xB → requester 1 receives 0xA and requester 0 receives 0xB; `outstanding_o` goes 1, 2, 1, 0.
- **Backpressure:** `mmio_req_ready_and_i=0` for 5 cycles in `e_addr` → address beat held stable; no yumi; grant unchanged.
- **Reset mid-data-beat:** `s_axi_aresetn` asserted low during `e_data` → all outputs 0 immediately; after release, the first grant goes to requester 0.
- **Timeout (macro on, `timeout_cycles_p=16`):** read with no host response → requester receives 0xDEADBEEF at cycle 16 after enqueue; `timeout_o=1`; a late host response 0x77 is consumed and not delivered.
